valu_sequencer: RTL and testbench

VALU_SEQUENCER -- requirements
Module: valu_sequencer

---
 rtl/valu_pkg.sv | 19 +
 rtl/valu_sequencer_if.sv | 44 ++++
 rtl/valu_lane_mask.sv | 19 +
 rtl/valu_sequencer.sv | 135 +++++++++++++
 tb/tb_valu_sequencer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/valu_pkg.sv
// rtl/valu_pkg.sv - shared types and constants for the vector ALU sequencer
package valu_pkg;

   localparam int unsigned MAX_VL = 48;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_FPMUL = 3'b010;
   localparam logic [2:0] OP_LT    = 3'b011;
   localparam logic [2:0] OP_MOV1  = 3'b110;
   localparam logic [2:0] OP_MOV2  = 3'b111;

endpackage

// File: rtl/valu_sequencer_if.sv
// rtl/valu_sequencer_if.sv - command, register-file, ALU and writeback bundle
interface valu_sequencer_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int LANES         = 6,
   parameter int SELECTOR_SIZE = 3,
   parameter int MAX_GROUPS    = 8
);
   logic                             cmd_valid;
   logic                             cmd_ready;
   logic [SELECTOR_SIZE-1:0]         cmd_sel;
   logic [5:0]                       cmd_vl;

   logic                             rf_rd_en;
   logic [2:0]                       rf_rd_group;
   logic [LANES*DATA_WIDTH-1:0]      rf_rd_data1;
   logic [LANES*DATA_WIDTH-1:0]      rf_rd_data2;

   logic [SELECTOR_SIZE-1:0]         alu_selector;
   logic [LANES*DATA_WIDTH-1:0]      alu_op1;
   logic [LANES*DATA_WIDTH-1:0]      alu_op2;
   logic [LANES*DATA_WIDTH-1:0]      alu_out;
   logic [LANES-1:0]                 alu_cmp;

   logic                             wb_valid;
   logic [2:0]                       wb_group;
   logic [LANES*DATA_WIDTH-1:0]      wb_data;
   logic [LANES-1:0]                 wb_lane_mask;
   logic [MAX_GROUPS*LANES-1:0]      cmp_mask;
   logic                             busy;
   logic                             done;

   // master is the sequencer; slave is the surrounding datapath
   modport master (
      input  cmd_valid, cmd_sel, cmd_vl, rf_rd_data1, rf_rd_data2, alu_out, alu_cmp,
      output cmd_ready, rf_rd_en, rf_rd_group, alu_selector, alu_op1, alu_op2,
             wb_valid, wb_group, wb_data, wb_lane_mask, cmp_mask, busy, done
   );

   modport slave (
      output cmd_valid, cmd_sel, cmd_vl, rf_rd_data1, rf_rd_data2, alu_out, alu_cmp,
      input  cmd_ready, rf_rd_en, rf_rd_group, alu_selector, alu_op1, alu_op2,
             wb_valid, wb_group, wb_data, wb_lane_mask, cmp_mask, busy, done
   );
endinterface

// File: rtl/valu_lane_mask.sv
// rtl/valu_lane_mask.sv - per-lane enable for one group given the vector length
module valu_lane_mask #(
   parameter int LANES = 6
) (
   input  logic [5:0]       vl,
   input  logic [2:0]       group_idx,
   output logic [LANES-1:0] mask
);
   logic [9:0] base;

   // Full groups fall out of the same compare, so no special last-group case
   always_comb begin
      mask = '0;
      base = 10'(group_idx) * 10'(LANES);
      for (int i = 0; i < LANES; i++) begin
         mask[i] = (base + 10'(i)) < 10'(vl);
      end
   end
endmodule

// File: rtl/valu_sequencer.sv
// rtl/valu_sequencer.sv - walks a vector command through register-file reads, ALU and writeback
module valu_sequencer
   import valu_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int LANES         = 6,
   parameter int SELECTOR_SIZE = 3,
   parameter int MAX_GROUPS    = 8
) (
   input  logic              clk,
   input  logic              rst,
   valu_sequencer_if.master  bus
);
   localparam int unsigned VL_LIMIT = MAX_GROUPS * LANES;

   state_t                   state;
   state_t                   state_next;
   logic [SELECTOR_SIZE-1:0] sel_q;
   logic [5:0]               vl_q;
   logic [3:0]               groups_q;
   logic [2:0]               issue_cnt;
   logic                     rd_pending;
   logic                     rd_last;
   logic [2:0]               rd_group_q;
   logic [LANES-1:0]         lane_mask;
   logic                     accept;
   logic                     issue_last;
   logic [5:0]               vl_eff;
   logic [3:0]               groups_eff;

   assign accept     = bus.cmd_valid && (state == S_IDLE);
   assign vl_eff     = (bus.cmd_vl > 6'(VL_LIMIT)) ? 6'(VL_LIMIT) : bus.cmd_vl;
   assign groups_eff = 4'((7'(vl_eff) + 7'(LANES - 1)) / 7'(LANES));
   assign issue_last = ({1'b0, issue_cnt} == (groups_q - 4'd1));

   valu_lane_mask #(.LANES(LANES)) u_lane_mask (
      .vl        (vl_q),
      .group_idx (rd_group_q),
      .mask      (lane_mask)
   );

   // Operands only pass through in the cycle read data is valid
   assign bus.alu_selector = sel_q;
   assign bus.alu_op1      = rd_pending ? bus.rf_rd_data1 : {LANES*DATA_WIDTH{1'b0}};
   assign bus.alu_op2      = rd_pending ? bus.rf_rd_data2 : {LANES*DATA_WIDTH{1'b0}};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next      = state;
      bus.cmd_ready   = 1'b0;
      bus.busy        = 1'b0;
      bus.rf_rd_en    = 1'b0;
      bus.rf_rd_group = '0;
      case (state)
         S_IDLE: begin
            bus.cmd_ready = 1'b1;
            if (accept) begin
               state_next = (groups_eff == 4'd0) ? S_DRAIN : S_ISSUE;
            end
         end
         S_ISSUE: begin
            bus.busy        = 1'b1;
            bus.rf_rd_en    = 1'b1;
            bus.rf_rd_group = issue_cnt;
            if (issue_last) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            bus.busy = 1'b1;
            if (bus.done) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q            <= '0;
         vl_q             <= '0;
         groups_q         <= '0;
         issue_cnt        <= '0;
         rd_pending       <= 1'b0;
         rd_last          <= 1'b0;
         rd_group_q       <= '0;
         bus.wb_valid     <= 1'b0;
         bus.wb_group     <= '0;
         bus.wb_data      <= '0;
         bus.wb_lane_mask <= '0;
         bus.cmp_mask     <= '0;
         bus.done         <= 1'b0;
      end else begin
         rd_pending   <= (state == S_ISSUE);
         rd_last      <= (state == S_ISSUE) && issue_last;
         rd_group_q   <= issue_cnt;
         bus.wb_valid <= 1'b0;
         bus.done     <= 1'b0;

         if (accept) begin
            sel_q        <= bus.cmd_sel;
            vl_q         <= vl_eff;
            groups_q     <= groups_eff;
            issue_cnt    <= '0;
            bus.cmp_mask <= '0;
            bus.done     <= (groups_eff == 4'd0);
         end

         if (state == S_ISSUE) begin
            issue_cnt <= issue_cnt + 3'd1;
         end

         // Compare results land in the mask instead of producing a writeback
         if (rd_pending) begin
            bus.wb_data      <= bus.alu_out;
            bus.wb_group     <= rd_group_q;
            bus.wb_lane_mask <= lane_mask;
            if (sel_q == OP_LT) begin
               bus.cmp_mask[int'(rd_group_q) * LANES +: LANES] <= bus.alu_cmp & lane_mask;
            end else begin
               bus.wb_valid <= 1'b1;
            end
            bus.done <= rd_last;
         end
      end
   end
endmodule

// File: tb/tb_valu_sequencer.sv
// tb/tb_valu_sequencer.sv - directed self-checking bench for valu_sequencer
module tb_valu_sequencer;
   import valu_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] cmp_pat = '0;
   int         n_checks = 0;
   int         n_fail = 0;

   valu_sequencer_if bus ();

   valu_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   function automatic logic [47:0] rf_word(input logic [2:0] g, input bit second);
      logic [47:0] w;
      w = '0;
      for (int i = 0; i < 6; i++) begin
         w[i*8 +: 8] = second ? 8'(i + 1) : 8'(int'(g) * 16 + i);
      end
      return w;
   endfunction

   function automatic logic [47:0] exp_data(input logic [2:0] sel, input int g);
      logic [47:0] r;
      logic [7:0]  a;
      logic [7:0]  b;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         a = 8'(g * 16 + i);
         b = 8'(i + 1);
         r[i*8 +: 8] = (sel == OP_ADD) ? a + b : (sel == OP_SUB) ? a - b : a;
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      bus.rf_rd_data1 <= bus.rf_rd_en ? rf_word(bus.rf_rd_group, 1'b0) : '0;
      bus.rf_rd_data2 <= bus.rf_rd_en ? rf_word(bus.rf_rd_group, 1'b1) : '0;
   end

   always_comb begin
      bus.alu_out = '0;
      for (int i = 0; i < 6; i++) begin
         case (bus.alu_selector)
            OP_ADD:  bus.alu_out[i*8 +: 8] = bus.alu_op1[i*8 +: 8] + bus.alu_op2[i*8 +: 8];
            OP_SUB:  bus.alu_out[i*8 +: 8] = bus.alu_op1[i*8 +: 8] - bus.alu_op2[i*8 +: 8];
            default: bus.alu_out[i*8 +: 8] = bus.alu_op1[i*8 +: 8];
         endcase
      end
      bus.alu_cmp = cmp_pat;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_cmd(input logic [2:0] sel, input logic [5:0] vl, input int groups,
                          input logic [5:0] last_mask, input bit noise);
      int rd_n;
      int wb_n;
      int done_k;
      bit seen;
      @(negedge clk);
      check_eq("ready_before", 64'(bus.cmd_ready), 64'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_sel   = sel;
      bus.cmd_vl    = vl;
      @(posedge clk);
      rd_n = 0; wb_n = 0; done_k = 0; seen = 1'b0;
      for (int k = 1; k <= 30 && !seen; k++) begin
         @(negedge clk);
         if (noise && k == 1) begin
            bus.cmd_sel = OP_MOV2;
            bus.cmd_vl  = 6'd63;
         end else if (!noise) begin
            bus.cmd_valid = 1'b0;
         end
         if (k == 1) begin
            check_eq("busy_t1", 64'(bus.busy), 64'd1);
            check_eq("cmp_clear_t1", 64'(bus.cmp_mask), 64'd0);
            check_eq("alu_sel", 64'(bus.alu_selector), 64'(sel));
         end
         if (bus.rf_rd_en) begin
            check_eq("rd_cycle", 64'(k), 64'(1 + rd_n));
            check_eq("rd_group", 64'(bus.rf_rd_group), 64'(rd_n));
            rd_n++;
         end
         if (bus.wb_valid) begin
            check_eq("wb_cycle", 64'(k), 64'(3 + wb_n));
            check_eq("wb_group", 64'(bus.wb_group), 64'(wb_n));
            check_eq("wb_mask", 64'(bus.wb_lane_mask),
                     64'((wb_n == groups - 1) ? last_mask : 6'h3f));
            check_eq("wb_data", 64'(bus.wb_data), 64'(exp_data(sel, wb_n)));
            wb_n++;
         end
         if (bus.done) begin
            done_k = k;
            seen = 1'b1;
            bus.cmd_valid = 1'b0;
         end
      end
      check_eq("done_cycle", 64'(done_k), 64'((groups == 0) ? 1 : 2 + groups));
      check_eq("rd_count", 64'(rd_n), 64'(groups));
      check_eq("wb_count", 64'(wb_n), 64'((sel == OP_LT) ? 0 : groups));
      @(negedge clk);
      check_eq("idle_after", 64'(bus.cmd_ready), 64'd1);
      check_eq("busy_after", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      int acc;
      int rd_n;
      int wb_n;
      int overlap;
      int late;
      bus.cmd_valid = 1'b0;
      bus.cmd_sel   = '0;
      bus.cmd_vl    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_eq("rst_ready", 64'(bus.cmd_ready), 64'd1);
      check_eq("rst_busy", 64'(bus.busy), 64'd0);
      check_eq("rst_rd_en", 64'(bus.rf_rd_en), 64'd0);
      check_eq("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
      check_eq("rst_done", 64'(bus.done), 64'd0);
      check_eq("rst_cmp_mask", 64'(bus.cmp_mask), 64'd0);

      run_cmd(OP_ADD, 6'd12, 2, 6'b111111, 1'b0);
      run_cmd(OP_SUB, 6'd13, 3, 6'b000001, 1'b1);

      cmp_pat = 6'b101010;
      run_cmd(OP_LT, 6'd8, 2, 6'b000011, 1'b0);
      check_eq("lt_cmp_mask", 64'(bus.cmp_mask), 64'h0AA);
      repeat (3) @(negedge clk);
      check_eq("lt_cmp_hold", 64'(bus.cmp_mask), 64'h0AA);
      run_cmd(OP_LT, 6'd0, 0, 6'b111111, 1'b0);
      check_eq("vl0_cmp_clear", 64'(bus.cmp_mask), 64'd0);

      run_cmd(OP_ADD, 6'd0, 0, 6'b111111, 1'b0);
      run_cmd(OP_ADD, 6'd63, 8, 6'b111111, 1'b0);

      // cmd_valid held high: one six-element command every four cycles
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_sel   = OP_ADD;
      bus.cmd_vl    = 6'd6;
      acc = 0; rd_n = 0; wb_n = 0; overlap = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.cmd_valid && bus.cmd_ready) acc++;
         if (bus.rf_rd_en) rd_n++;
         if (bus.wb_valid) wb_n++;
         if (bus.rf_rd_en && bus.cmd_ready) overlap++;
         @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
      check_eq("b2b_accepts", 64'(acc), 64'd5);
      check_eq("b2b_reads", 64'(rd_n), 64'd5);
      check_eq("b2b_writebacks", 64'(wb_n), 64'd5);
      check_eq("b2b_overlap", 64'(overlap), 64'd0);

      // Abort a full-length command with reset in its third cycle
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_sel   = OP_ADD;
      bus.cmd_vl    = 6'd48;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("abort_ready", 64'(bus.cmd_ready), 64'd1);
      check_eq("abort_busy", 64'(bus.busy), 64'd0);
      check_eq("abort_cmp_mask", 64'(bus.cmp_mask), 64'd0);
      late = 0;
      for (int c = 0; c < 12; c++) begin
         if (bus.rf_rd_en || bus.wb_valid || bus.done) late++;
         @(negedge clk);
      end
      check_eq("abort_quiet", 64'(late), 64'd0);
      run_cmd(OP_ADD, 6'd12, 2, 6'b111111, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
